// File: rtl/ptp_tod_wb_if.sv
// Wishbone classic bus bundle between the SoC master and the time-of-day slave.
interface ptp_tod_wb_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_ack_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/ptp_tod_wb.sv
// PTP time-of-day counter (48-bit seconds, 30-bit ns, 24-bit fractional ns)
// behind a Wishbone classic slave. Firmware loads, trims and snapshots time;
// the live ToD and a 1PPS pulse go straight to the MAC timestamp logic.
module ptp_tod_wb #(
  parameter logic [31:0] DEFAULT_INC = 32'h5355_5555,
  parameter int          NS_PER_SEC  = 1_000_000_000,
  parameter logic        ENABLE_RST  = 1'b1
) (
  input  logic        clock_main,
  input  logic        rst,
  ptp_tod_wb_if.slave wb,
  output logic [47:0] tod_sec,
  output logic [29:0] tod_ns,
  output logic        pps
);

  typedef enum logic [3:0] {
    A_CTRL        = 4'h0,
    A_INC         = 4'h1,
    A_ADJ         = 4'h2,
    A_LD_NS       = 4'h3,
    A_LD_SEC_LO   = 4'h4,
    A_LD_SEC_HI   = 4'h5,
    A_SNAP_NS     = 4'h6,
    A_SNAP_SEC_LO = 4'h7,
    A_SNAP_SEC_HI = 4'h8
  } reg_addr_e;

  localparam logic        [30:0] NS_LIMIT   = 31'(NS_PER_SEC);
  localparam logic signed [33:0] NS_LIMIT_S = 34'(NS_PER_SEC);

  // Programmable registers
  logic        enable;
  logic [31:0] inc_q;
  logic [31:0] adj_q;
  logic [29:0] ld_ns;
  logic [31:0] ld_sec_lo;
  logic [15:0] ld_sec_hi;
  logic [47:0] snap_sec;
  logic [23:0] frac;

  // Bus decode
  reg_addr_e   adr_sel;
  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic        ctrl_wr;
  logic        load_go;
  logic        adjust_go;
  logic [31:0] rd_data;
  logic [31:0] wr_merged;
  logic        unused_adr_bits;

  // Counter next state
  logic [24:0]        frac_sum;
  logic [30:0]        ns_inc;
  logic [30:0]        adj_base;
  logic signed [33:0] adj_t;
  logic [29:0]        ns_nxt;
  logic [47:0]        sec_nxt;
  logic [23:0]        frac_nxt;
  logic               pps_nxt;

  assign adr_sel         = reg_addr_e'(wb.wbs_adr_i[5:2]);
  assign unused_adr_bits = ^{wb.wbs_adr_i[31:6], wb.wbs_adr_i[1:0]};

  // The accept edge is the one on which ack rises; ack can never repeat.
  assign accept    = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
  assign wr_en     = accept & wb.wbs_we_i;
  assign rd_en     = accept & ~wb.wbs_we_i;
  assign ctrl_wr   = wr_en & (adr_sel == A_CTRL) & wb.wbs_sel_i[0];
  assign load_go   = ctrl_wr & wb.wbs_dat_i[1];
  // Load and adjust together: load wins and the adjust is dropped.
  assign adjust_go = ctrl_wr & wb.wbs_dat_i[2] & ~wb.wbs_dat_i[1];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Read mux; also supplies the current contents for byte-lane merging.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    case (adr_sel)
      A_CTRL:        rd_data = {31'h0, enable};
      A_INC:         rd_data = inc_q;
      A_ADJ:         rd_data = adj_q;
      A_LD_NS:       rd_data = {2'b00, ld_ns};
      A_LD_SEC_LO:   rd_data = ld_sec_lo;
      A_LD_SEC_HI:   rd_data = {16'h0, ld_sec_hi};
      A_SNAP_NS:     rd_data = {2'b00, tod_ns};
      A_SNAP_SEC_LO: rd_data = snap_sec[31:0];
      A_SNAP_SEC_HI: rd_data = {16'h0, snap_sec[47:32]};
      default:       rd_data = '0;
    endcase
  end

  assign wr_merged = merge_lanes(rd_data, wb.wbs_dat_i, wb.wbs_sel_i);

  // Bus handshake, register writes and seconds snapshot on the accept edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_main) begin
    if (rst) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      enable       <= ENABLE_RST;
      inc_q        <= DEFAULT_INC;
      adj_q        <= '0;
      ld_ns        <= '0;
      ld_sec_lo    <= '0;
      ld_sec_hi    <= '0;
      snap_sec     <= '0;
    end else begin
      wb.wbs_ack_o <= accept;
      // Reading SNAP_NS captures live ns here and live sec in snap_sec, so
      // the read data register itself holds the coherent ns half.
      wb.wbs_dat_o <= rd_en ? rd_data : '0;
      if (rd_en && adr_sel == A_SNAP_NS) begin
        snap_sec <= tod_sec;
      end
      if (wr_en) begin
        case (adr_sel)
          A_CTRL:      if (wb.wbs_sel_i[0]) enable <= wb.wbs_dat_i[0];
          A_INC:       inc_q     <= wr_merged;
          A_ADJ:       adj_q     <= wr_merged;
          A_LD_NS:     ld_ns     <= wr_merged[29:0];
          A_LD_SEC_LO: ld_sec_lo <= wr_merged;
          A_LD_SEC_HI: ld_sec_hi <= wr_merged[15:0];
          default:     ;
        endcase
      end
    end
  end

  // Counter next state: load, then adjust, then free-running increment.
  always_comb begin
    frac_sum = {1'b0, frac} + {1'b0, inc_q[23:0]};
    ns_inc   = {1'b0, tod_ns} + {23'h0, inc_q[31:24]} + {30'h0, frac_sum[24]};
    adj_base = enable ? ns_inc : {1'b0, tod_ns};
    adj_t    = $signed({3'b000, adj_base}) + $signed({{2{adj_q[31]}}, adj_q});

    ns_nxt   = tod_ns;
    sec_nxt  = tod_sec;
    frac_nxt = frac;
    pps_nxt  = 1'b0;

    if (load_go) begin
      ns_nxt   = ld_ns;
      sec_nxt  = {ld_sec_hi, ld_sec_lo};
      frac_nxt = '0;
    end else if (adjust_go) begin
      if (enable) frac_nxt = frac_sum[23:0];
      if (adj_t[33]) begin
        ns_nxt  = 30'(adj_t + NS_LIMIT_S);
        sec_nxt = tod_sec - 48'd1;
      end else if (adj_t >= NS_LIMIT_S) begin
        ns_nxt  = 30'(adj_t - NS_LIMIT_S);
        sec_nxt = tod_sec + 48'd1;
        pps_nxt = 1'b1;
      end else begin
        ns_nxt  = adj_t[29:0];
      end
    end else if (enable) begin
      frac_nxt = frac_sum[23:0];
      if (ns_inc >= NS_LIMIT) begin
        ns_nxt  = 30'(ns_inc - NS_LIMIT);
        sec_nxt = tod_sec + 48'd1;
        pps_nxt = 1'b1;
      end else begin
        ns_nxt  = ns_inc[29:0];
      end
    end
  end

  // Time-of-day registers drive the outputs directly; pps marks each +1 second step.
  always_ff @(posedge clock_main) begin
    if (rst) begin
      tod_ns  <= '0;
      tod_sec <= '0;
      frac    <= '0;
      pps     <= 1'b0;
    end else begin
      tod_ns  <= ns_nxt;
      tod_sec <= sec_nxt;
      frac    <= frac_nxt;
      pps     <= pps_nxt;
    end
  end

endmodule

// File: tb/tb_ptp_tod_wb.sv
// Self-checking bench for ptp_tod_wb: a fixed-point time model tracks the
// expected counter, bus and pps behaviour and is compared every cycle.
module tb_ptp_tod_wb;

  localparam longint NS = 1_000_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] tod_sec;
  logic [29:0] tod_ns;
  logic        pps;

  int total = 0;
  int bad   = 0;

  ptp_tod_wb_if wb ();

  ptp_tod_wb dut (
    .clock_main (clk),
    .rst        (rst),
    .wb         (wb),
    .tod_sec    (tod_sec),
    .tod_ns     (tod_ns),
    .pps        (pps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  logic        m_ack, m_pps, m_en;
  logic [31:0] m_dat, m_inc, m_adj, m_ld_ns, rv, wd, tmp;
  logic [47:0] m_sec, m_ld_sec, m_snap;
  longint      m_ns, m_frac, fx, t;
  logic        acc, cwr, do_ld, do_adj;
  logic [3:0]  idx;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ack = 0; m_dat = 0; m_pps = 0; m_sec = 0; m_ns = 0; m_frac = 0;
      m_inc = 32'h5355_5555; m_adj = 0; m_ld_ns = 0; m_ld_sec = 0; m_snap = 0; m_en = 1;
    end else begin
      acc = wb.wbs_stb_i && wb.wbs_cyc_i && !m_ack;
      idx = wb.wbs_adr_i[5:2];
      wd  = wb.wbs_dat_i;
      case (idx)
        4'd0: rv = {31'h0, m_en};
        4'd1: rv = m_inc;
        4'd2: rv = m_adj;
        4'd3: rv = m_ld_ns;
        4'd4: rv = m_ld_sec[31:0];
        4'd5: rv = {16'h0, m_ld_sec[47:32]};
        4'd6: rv = 32'(m_ns);
        4'd7: rv = m_snap[31:0];
        4'd8: rv = {16'h0, m_snap[47:32]};
        default: rv = 0;
      endcase
      if (acc && !wb.wbs_we_i && idx == 4'd6) m_snap = m_sec;
      cwr    = acc && wb.wbs_we_i && idx == 4'd0 && wb.wbs_sel_i[0];
      do_ld  = cwr && wd[1];
      do_adj = cwr && wd[2] && !wd[1];
      // Time kept as ns*2^24 + frac; one second = NS*2^24.
      m_pps = 0;
      if (do_ld) begin
        m_ns = m_ld_ns; m_sec = m_ld_sec; m_frac = 0;
      end else if (do_adj) begin
        fx = (m_ns <<< 24) + m_frac + (m_en ? longint'(m_inc) : 64'sd0);
        t  = (fx >>> 24) + longint'($signed(m_adj));
        if (m_en) m_frac = fx & 64'hFF_FFFF;
        if (t < 0) begin t = t + NS; m_sec = m_sec - 48'd1; end
        else if (t >= NS) begin t = t - NS; m_sec = m_sec + 48'd1; m_pps = 1; end
        m_ns = t;
      end else if (m_en) begin
        fx = (m_ns <<< 24) + m_frac + longint'(m_inc);
        if (fx >= (NS <<< 24)) begin fx = fx - (NS <<< 24); m_sec = m_sec + 48'd1; m_pps = 1; end
        m_ns = fx >>> 24; m_frac = fx & 64'hFF_FFFF;
      end
      if (acc && wb.wbs_we_i) begin
        case (idx)
          4'd0: if (wb.wbs_sel_i[0]) m_en = wd[0];
          4'd1: m_inc = lanes(m_inc, wd, wb.wbs_sel_i);
          4'd2: m_adj = lanes(m_adj, wd, wb.wbs_sel_i);
          4'd3: m_ld_ns = lanes(m_ld_ns, wd, wb.wbs_sel_i) & 32'h3FFF_FFFF;
          4'd4: m_ld_sec[31:0] = lanes(m_ld_sec[31:0], wd, wb.wbs_sel_i);
          4'd5: begin
            tmp = lanes({16'h0, m_ld_sec[47:32]}, wd, wb.wbs_sel_i);
            m_ld_sec[47:32] = tmp[15:0];
          end
          default: ;
        endcase
      end
      m_ack = acc;
      m_dat = (acc && !wb.wbs_we_i) ? rv : 32'h0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("ack", wb.wbs_ack_o, m_ack);
      check("tod_ns", tod_ns, m_ns);
      check("tod_sec", tod_sec, m_sec);
      check("pps", pps, m_pps);
      if (m_ack) check("rdata", wb.wbs_dat_o, m_dat);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    check("ack_one_cycle", wb.wbs_ack_o, 1'b0);
    wb.wbs_adr_i = a; wb.wbs_dat_i = d; wb.wbs_we_i = w; wb.wbs_sel_i = s;
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb.wbs_ack_o && n < 8);
    check("ack_seen", wb.wbs_ack_o, 1'b1);
    rd = wb.wbs_dat_o;
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] dummy;
    wb_cycle(a, 1'b1, d, s, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
    wb_cycle(a, 1'b0, 32'h0, 4'hF, rd);
  endtask

  task automatic load_time(input logic [29:0] ns, input logic [47:0] sec, input logic [31:0] ctrl);
    wb_wr(32'h0C, {2'b00, ns});
    wb_wr(32'h10, sec[31:0]);
    wb_wr(32'h14, {16'h0, sec[47:32]});
    wb_wr(32'h00, ctrl);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] r;
    wb.wbs_adr_i = 0; wb.wbs_dat_i = 0; wb.wbs_we_i = 0; wb.wbs_sel_i = 0;
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and default registers
    check("rst_ns", tod_ns, 0);
    check("rst_sec", tod_sec, 0);
    check("rst_pps", pps, 0);
    check("rst_ack", wb.wbs_ack_o, 0);
    wb_rd(32'h04, r); check("t1_inc", r, 32'h5355_5555);
    wb_rd(32'h00, r); check("t1_ctrl", r, 32'h1);

    // Load while running with 10 ns/clock, roll into the next second
    wb_wr(32'h04, 32'h0A00_0000);
    load_time(30'd999_999_990, 48'd5, 32'h3);
    check("t2_load_ns", tod_ns, 999_999_990);
    check("t2_load_sec", tod_sec, 5);
    @(posedge clk); #1;
    check("t2_ns", tod_ns, 0);
    check("t2_sec", tod_sec, 6);
    check("t2_pps", pps, 1);
    check("t2_model_sec", m_sec, 6);
    check("t2_model_pps", m_pps, 1);
    @(posedge clk); #1;
    check("t2_pps_off", pps, 0);
    check("t2_ns_next", tod_ns, 10);

    // Stopped negative adjust borrows a second, no pps
    wb_wr(32'h00, 32'h0);
    load_time(30'd100, 48'd1, 32'h2);
    wb_wr(32'h08, 32'hFFFF_FF38);
    wb_wr(32'h00, 32'h4);
    check("t3_ns", tod_ns, 999_999_900);
    check("t3_sec", tod_sec, 0);
    check("t3_pps", pps, 0);
    check("t3_model_ns", m_ns, 999_999_900);
    // sec - 1 from zero wraps to all ones
    wb_wr(32'h08, 32'hC465_3632);
    wb_wr(32'h00, 32'h4);
    check("t3_wrap_ns", tod_ns, 999_999_950);
    check("t3_wrap_sec", tod_sec, 48'hFFFF_FFFF_FFFF);
    check("t3_wrap_pps", pps, 0);

    // Positive adjust carries a second and pulses pps
    wb_wr(32'h04, 32'h0);
    load_time(30'd999_999_995, 48'd2, 32'h2);
    wb_wr(32'h08, 32'd10);
    wb_wr(32'h00, 32'h5);
    check("t4_ns", tod_ns, 5);
    check("t4_sec", tod_sec, 3);
    check("t4_pps", pps, 1);
    @(posedge clk); #1;
    check("t4_pps_off", pps, 0);
    check("t4_hold_ns", tod_ns, 5);

    // sec + 1 from all ones wraps to zero
    wb_wr(32'h04, 32'h0A00_0000);
    load_time(30'd999_999_990, 48'hFFFF_FFFF_FFFF, 32'h3);
    @(posedge clk); #1;
    check("wrap_sec", tod_sec, 0);
    check("wrap_pps", pps, 1);

    // Snapshot stays coherent across a rollover between the reads
    load_time(30'd999_999_970, 48'h0001_FFFF_FFFF, 32'h3);
    wb_rd(32'h18, r); check("t5_snap_ns", r, 999_999_980);
    wb_rd(32'h1C, r); check("t5_snap_lo", r, 32'hFFFF_FFFF);
    wb_rd(32'h20, r); check("t5_snap_hi", r, 32'h0000_0001);
    check("t5_live_sec", tod_sec, 48'h0002_0000_0000);

    // Unmapped access, lane masking, load beats adjust
    wb_rd(32'h3C, r); check("t6_unmapped_rd", r, 0);
    wb_wr(32'h3C, 32'hFFFF_FFFF);
    wb_rd(32'h04, r); check("t6_inc_kept", r, 32'h0A00_0000);
    wb_rd(32'h00, r); check("t6_ctrl_kept", r, 32'h1);
    wb_wr(32'h04, 32'hAABB_CCDD, 4'b0010);
    wb_rd(32'h04, r); check("lane_inc", r, 32'h0A00_CC00);
    wb_wr(32'h00, 32'h0);
    wb_wr(32'h00, 32'h1, 4'b1110);
    wb_rd(32'h00, r); check("lane_ctrl", r, 32'h0);
    wb_wr(32'h08, 32'd1000);
    load_time(30'd123, 48'd7, 32'h6);
    check("t6_load_ns", tod_ns, 123);
    check("t6_load_sec", tod_sec, 7);
    check("t6_load_pps", pps, 0);

    // Reset in the middle of a transfer drops ack
    @(posedge clk); #1;
    wb.wbs_adr_i = 32'h04; wb.wbs_we_i = 1'b0; wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ack", wb.wbs_ack_o, 0);
    check("mid_rst_ns", tod_ns, 0);
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
    rst = 1'b0;
    wb_rd(32'h04, r); check("mid_rst_inc", r, 32'h5355_5555);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
